hls_uint16_to_fp17_chn_o_pipe: RTL and testbench
================================================

HLS_UINT16_TO_FP17_CHN_O_PIPE -- requirements
Module: hls_uint16_to_fp17_chn_o_pipe

Interface
REQ-001 The block SHALL have one clock, nvdla_core_clk, and an asynchronous, active-low reset, nvdla_core_rstn.
REQ-002 Parameter DW, default 17: fp17 payload width.
REQ-003 Parameter DEPTH, default 2: buffer entries; legal values are 2 and 4.
REQ-004 Ports:
- nvdla_core_clk  in  1  clock, rising edge.
- nvdla_core_rstn  in  1  async active-low reset.
- chn_o_rsci_ivld  in  1  core write strobe; one fp17 result per asserted cycle.
- chn_o_rsci_idat  in  DW  core result data.
- chn_o_rsci_vd  out  1  space available; consumed by the core-side wait control.
- chn_o_pd  out  DW  downstream payload.
- chn_o_pvld  out  1  downstream valid.
- chn_o_prdy  in  1  downstream ready.
- chn_o_cnt  out  clog2(DEPTH)+1  current occupancy.
- chn_o_ovf_err  out  1  sticky flag: write attempted while full.

Function
REQ-005 Storage SHALL be a DEPTH-entry FIFO with write pointer wr_ptr, read pointer rd_ptr and occupancy counter cnt.
REQ-006 Occupancy states: EMPTY (cnt=0), PART (0<cnt<DEPTH), FULL (cnt=DEPTH).
REQ-007 chn_o_rsci_vd SHALL equal (cnt != DEPTH), decoded directly from the cnt register, with no combinational path from chn_o_prdy.
REQ-008 A push SHALL occur when chn_o_rsci_ivld && chn_o_rsci_vd; chn_o_rsci_idat is captured at wr_ptr, and wr_ptr increments modulo DEPTH.
REQ-009 A pop SHALL occur when chn_o_pvld && chn_o_prdy; rd_ptr increments modulo DEPTH.
REQ-010 chn_o_pvld SHALL equal (cnt != 0), and chn_o_pd SHALL equal mem[rd_ptr].
REQ-011 Latency from push to chn_o_pvld SHALL be 1 cycle; there is no same-cycle bypass.
REQ-012 Push and pop in the same cycle SHALL leave cnt unchanged and advance both pointers.
- In EMPTY, a simultaneous push/pop cannot occur (pvld=0).
- In FULL, a simultaneous push/pop cannot occur (vd=0).
REQ-013 Transitions:
- EMPTY to PART on push.
- PART to FULL on push without pop when cnt=DEPTH-1.
- PART to EMPTY on pop without push when cnt=1.
- FULL to PART on pop.
- All other combinations hold state.
REQ-014 chn_o_pd SHALL hold stable while chn_o_pvld=1 and chn_o_prdy=0.
REQ-015 chn_o_rsci_ivld=1 while FULL SHALL drop the data, leave FIFO state unchanged, and set chn_o_ovf_err, which stays set until reset.
REQ-016 chn_o_cnt SHALL mirror cnt.
REQ-017 Pointer wrap: the pointer value DEPTH-1 increments to 0.
REQ-018 Throughput: one push and one pop per cycle SHALL be sustainable indefinitely in PART.

Reset
REQ-019 On nvdla_core_rstn low, asynchronously:
- cnt, wr_ptr, rd_ptr, chn_o_ovf_err SHALL clear to 0.
- Resulting outputs: chn_o_pvld=0, chn_o_rsci_vd=1, chn_o_cnt=0.
REQ-020 Storage array contents are not reset; chn_o_pd is don't-care while chn_o_pvld=0.
REQ-021 Reset asserted mid-transfer SHALL discard all buffered entries; the first push after release is the first pop.

Structure
REQ-022 The package hls_uint16_to_fp17_pkg SHALL hold:
- DW, DEPTH defaults;
- the occupancy state enum (EMPTY/PART/FULL);
- the cnt width constant.
REQ-023 Storage SHALL be a single sub-module, hls_uint16_to_fp17_chn_o_mem: DEPTH x DW register array, one write port, one async read port.
REQ-024 Pointer, counter and flag logic SHALL reside in the top module.

Verification
REQ-025 Reset then idle: chn_o_pvld=0, chn_o_rsci_vd=1, chn_o_cnt=0, chn_o_ovf_err=0.
REQ-026 Single push 0x1ABCD with prdy=1: pvld=1 with chn_o_pd=0x1ABCD exactly one cycle later; cnt returns to 0 the following cycle.
REQ-027 prdy=0, pushes 0x00001 then 0x00002: cnt=2, vd=0, pd stays 0x00001. Raise prdy: outputs 0x00001 then 0x00002 in order; vd returns to 1 after the first pop.
REQ-028 Full plus push 0x0FFFF with prdy=0: data dropped, ovf_err=1 and sticky; later pops return only the two earlier values.
REQ-029 Streaming 100 incrementing values with ivld=1 and prdy=1 continuous: one output per cycle after the first, order preserved, pointer wraps exercised, ovf_err=0.
REQ-030 Assert reset while cnt=2: immediately pvld=0, vd=1. Next push 0x00055 after release appears as the first output.

Source files
------------

// File: rtl/hls_uint16_to_fp17_pkg.sv
`default_nettype none
// ============================================================================
// hls_uint16_to_fp17_pkg : shared widths and occupancy encoding for chn_o pipe
// Revision 1.0
// ============================================================================
package hls_uint16_to_fp17_pkg;

  localparam int DW_DEFAULT    = 17;
  localparam int DEPTH_DEFAULT = 2;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_PART  = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // Occupancy counter must hold the value DEPTH itself, hence the extra bit.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int CNT_W_DEFAULT = cnt_width(DEPTH_DEFAULT);

endpackage
`default_nettype wire

// File: rtl/hls_uint16_to_fp17_chn_o_pipe_if.sv
`default_nettype none
// ============================================================================
// hls_uint16_to_fp17_chn_o_pipe_if : core-side write and downstream valid/ready
// Revision 1.0
// ============================================================================
interface hls_uint16_to_fp17_chn_o_pipe_if
  import hls_uint16_to_fp17_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int CW = CNT_W_DEFAULT
) ();

  logic          chn_o_rsci_ivld;
  logic [DW-1:0] chn_o_rsci_idat;
  logic          chn_o_rsci_vd;
  logic [DW-1:0] chn_o_pd;
  logic          chn_o_pvld;
  logic          chn_o_prdy;
  logic [CW-1:0] chn_o_cnt;
  logic          chn_o_ovf_err;

  modport master (
    output chn_o_rsci_ivld, chn_o_rsci_idat, chn_o_prdy,
    input  chn_o_rsci_vd, chn_o_pd, chn_o_pvld, chn_o_cnt, chn_o_ovf_err
  );

  modport slave (
    input  chn_o_rsci_ivld, chn_o_rsci_idat, chn_o_prdy,
    output chn_o_rsci_vd, chn_o_pd, chn_o_pvld, chn_o_cnt, chn_o_ovf_err
  );

endinterface
`default_nettype wire

// File: rtl/hls_uint16_to_fp17_chn_o_mem.sv
`default_nettype none
// ============================================================================
// hls_uint16_to_fp17_chn_o_mem : DEPTH x DW register array, 1 write, 1 async read
// Revision 1.0
// ============================================================================
module hls_uint16_to_fp17_chn_o_mem #(
  parameter int DW    = 17,
  parameter int DEPTH = 2,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [PW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [PW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  // Contents are intentionally left unreset; validity is tracked by the counter.
  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/hls_uint16_to_fp17_chn_o_pipe.sv
`default_nettype none
// ============================================================================
// hls_uint16_to_fp17_chn_o_pipe : fp17 output skid FIFO with sticky overflow flag
// Revision 1.0
// ============================================================================
module hls_uint16_to_fp17_chn_o_pipe
  import hls_uint16_to_fp17_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                          nvdla_core_clk,
  input  logic                          nvdla_core_rstn,
  hls_uint16_to_fp17_chn_o_pipe_if.slave chn_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] c_cnt_full = CW'(DEPTH);
  localparam logic [PW-1:0] c_ptr_last = PW'(DEPTH - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          ovf_err_q, ovf_err_d;
  occ_e          w_occ;
  logic          w_vd, w_pvld, w_push, w_pop;
  logic [DW-1:0] w_rdata;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == c_ptr_last) ? '0 : p + 1'b1;
  endfunction

  // Both handshake flags come straight from cnt_q so vd has no path from prdy.
  assign w_vd   = (cnt_q != c_cnt_full);
  assign w_pvld = (cnt_q != '0);
  assign w_push = chn_o.chn_o_rsci_ivld && w_vd;
  assign w_pop  = w_pvld && chn_o.chn_o_prdy;

  always_comb begin
    w_occ = OCC_PART;
    if (cnt_q == '0) begin
      w_occ = OCC_EMPTY;
    end else if (cnt_q == c_cnt_full) begin
      w_occ = OCC_FULL;
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ovf_err_d = ovf_err_q | (chn_o.chn_o_rsci_ivld & ~w_vd);
    case (w_occ)
      OCC_EMPTY: if (w_push) cnt_d = cnt_q + 1'b1;
      OCC_PART: begin
        if (w_push && !w_pop) begin
          cnt_d = cnt_q + 1'b1;
        end else if (w_pop && !w_push) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      OCC_FULL:  if (w_pop) cnt_d = cnt_q - 1'b1;
      default:   cnt_d = cnt_q;
    endcase
    if (w_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (w_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ovf_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ovf_err_q <= ovf_err_d;
    end
  end

  hls_uint16_to_fp17_chn_o_mem #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_mem (
    .clk_i   (nvdla_core_clk),
    .we_i    (w_push),
    .waddr_i (wr_ptr_q),
    .wdata_i (chn_o.chn_o_rsci_idat),
    .raddr_i (rd_ptr_q),
    .rdata_o (w_rdata)
  );

  assign chn_o.chn_o_rsci_vd = w_vd;
  assign chn_o.chn_o_pvld    = w_pvld;
  assign chn_o.chn_o_pd      = w_rdata;
  assign chn_o.chn_o_cnt     = cnt_q;
  assign chn_o.chn_o_ovf_err = ovf_err_q;

endmodule
`default_nettype wire

// File: tb/tb_hls_uint16_to_fp17_chn_o_pipe.sv
`default_nettype none
// ============================================================================
// tb_hls_uint16_to_fp17_chn_o_pipe : directed + randomized bench with queue model
// Revision 1.0
// ============================================================================
module tb_hls_uint16_to_fp17_chn_o_pipe;
  import hls_uint16_to_fp17_pkg::*;

  localparam int DW    = DW_DEFAULT;
  localparam int DEPTH = DEPTH_DEFAULT;
  localparam int CW    = CNT_W_DEFAULT;
  localparam logic [CW+2:0] ST_IDLE = {1'b1 == 1'b0, 1'b1, {CW{1'b0}}, 1'b0};

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  hls_uint16_to_fp17_chn_o_pipe_if #(.DW(DW), .CW(CW)) bus ();

  hls_uint16_to_fp17_chn_o_pipe #(.DW(DW), .DEPTH(DEPTH)) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .chn_o           (bus)
  );

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] mq[$];
  bit            m_ovf;

  // {pvld, vd, cnt, ovf_err}
  function automatic logic [CW+2:0] dut_status();
    return {bus.chn_o_pvld, bus.chn_o_rsci_vd, bus.chn_o_cnt, bus.chn_o_ovf_err};
  endfunction

  function automatic logic [CW+2:0] m_status();
    return {mq.size() != 0, mq.size() != DEPTH, CW'(mq.size()), m_ovf};
  endfunction

  task automatic cycle();
    bit            full, do_pop, do_push;
    logic [DW-1:0] d;
    full    = (mq.size() == DEPTH);
    do_pop  = bus.chn_o_prdy && (mq.size() != 0);
    do_push = bus.chn_o_rsci_ivld;
    d       = bus.chn_o_rsci_idat;
    @(posedge clk);
    if (do_pop) void'(mq.pop_front());
    if (do_push) begin
      if (full) m_ovf = 1'b1;
      else      mq.push_back(d);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.chn_o_rsci_ivld = 1'b0;
    bus.chn_o_rsci_idat = '0;
    bus.chn_o_prdy      = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    #1;
    n_tests++;
    if (dut_status() !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_async: got %b want %b", dut_status(), ST_IDLE);
    end
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) cycle();
    n_tests++;
    if (dut_status() !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_idle: got %b want %b", dut_status(), ST_IDLE);
    end
  endtask

  task automatic test_single();
    bus.chn_o_prdy      = 1'b1;
    bus.chn_o_rsci_ivld = 1'b1;
    bus.chn_o_rsci_idat = 17'h1ABCD;
    cycle();
    bus.chn_o_rsci_ivld = 1'b0;
    n_tests++;
    if (bus.chn_o_pvld !== 1'b1 || bus.chn_o_pd !== 17'h1ABCD) begin
      n_fail++;
      $display("FAIL single_out: got pvld=%b pd=%h want pvld=1 pd=1abcd", bus.chn_o_pvld, bus.chn_o_pd);
    end
    n_tests++;
    if (dut_status() !== m_status()) begin
      n_fail++;
      $display("FAIL single_status: got %b want %b", dut_status(), m_status());
    end
    cycle();
    n_tests++;
    if (bus.chn_o_cnt !== CW'(0) || bus.chn_o_pvld !== 1'b0) begin
      n_fail++;
      $display("FAIL single_drain: got cnt=%0d pvld=%b want cnt=0 pvld=0", bus.chn_o_cnt, bus.chn_o_pvld);
    end
  endtask

  task automatic test_backpressure();
    bus.chn_o_prdy = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      bus.chn_o_rsci_ivld = 1'b1;
      bus.chn_o_rsci_idat = DW'(i);
      cycle();
    end
    bus.chn_o_rsci_ivld = 1'b0;
    n_tests++;
    if (bus.chn_o_cnt !== CW'(2) || bus.chn_o_rsci_vd !== 1'b0 || bus.chn_o_pd !== 17'h00001) begin
      n_fail++;
      $display("FAIL bp_full: got cnt=%0d vd=%b pd=%h want cnt=2 vd=0 pd=00001",
               bus.chn_o_cnt, bus.chn_o_rsci_vd, bus.chn_o_pd);
    end
    cycle();
    n_tests++;
    if (bus.chn_o_pd !== 17'h00001 || bus.chn_o_pvld !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_hold: got pd=%h pvld=%b want pd=00001 pvld=1", bus.chn_o_pd, bus.chn_o_pvld);
    end
    bus.chn_o_prdy = 1'b1;
    cycle();
    n_tests++;
    if (bus.chn_o_pd !== 17'h00002 || bus.chn_o_rsci_vd !== 1'b1 || bus.chn_o_cnt !== CW'(1)) begin
      n_fail++;
      $display("FAIL bp_pop1: got pd=%h vd=%b cnt=%0d want pd=00002 vd=1 cnt=1",
               bus.chn_o_pd, bus.chn_o_rsci_vd, bus.chn_o_cnt);
    end
    cycle();
    n_tests++;
    if (dut_status() !== m_status()) begin
      n_fail++;
      $display("FAIL bp_drain: got %b want %b", dut_status(), m_status());
    end
    bus.chn_o_prdy = 1'b0;
  endtask

  task automatic test_stream();
    int bad = 0;
    bus.chn_o_prdy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      bus.chn_o_rsci_ivld = 1'b1;
      bus.chn_o_rsci_idat = DW'(i);
      cycle();
      n_tests++;
      if (bus.chn_o_pvld !== 1'b1 || bus.chn_o_pd !== DW'(i) || bus.chn_o_ovf_err !== 1'b0) begin
        n_fail++;
        bad++;
        if (bad < 5)
          $display("FAIL stream_%0d: got pvld=%b pd=%h ovf=%b want pvld=1 pd=%h ovf=0",
                   i, bus.chn_o_pvld, bus.chn_o_pd, bus.chn_o_ovf_err, DW'(i));
      end
    end
    bus.chn_o_rsci_ivld = 1'b0;
    cycle();
    n_tests++;
    if (dut_status() !== ST_IDLE) begin
      n_fail++;
      $display("FAIL stream_end: got %b want %b", dut_status(), ST_IDLE);
    end
    bus.chn_o_prdy = 1'b0;
  endtask

  task automatic test_overflow();
    bus.chn_o_prdy = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      bus.chn_o_rsci_ivld = 1'b1;
      bus.chn_o_rsci_idat = (i == 3) ? 17'h0FFFF : DW'(i);
      cycle();
    end
    bus.chn_o_rsci_ivld = 1'b0;
    n_tests++;
    if (bus.chn_o_ovf_err !== 1'b1 || bus.chn_o_cnt !== CW'(2) || bus.chn_o_pd !== 17'h00001) begin
      n_fail++;
      $display("FAIL ovf_set: got ovf=%b cnt=%0d pd=%h want ovf=1 cnt=2 pd=00001",
               bus.chn_o_ovf_err, bus.chn_o_cnt, bus.chn_o_pd);
    end
    bus.chn_o_prdy = 1'b1;
    cycle();
    n_tests++;
    if (bus.chn_o_pd !== 17'h00002 || bus.chn_o_cnt !== CW'(1)) begin
      n_fail++;
      $display("FAIL ovf_pop: got pd=%h cnt=%0d want pd=00002 cnt=1", bus.chn_o_pd, bus.chn_o_cnt);
    end
    repeat (3) cycle();
    n_tests++;
    if (dut_status() !== m_status() || bus.chn_o_ovf_err !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky: got %b want %b", dut_status(), m_status());
    end
    bus.chn_o_prdy = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.chn_o_prdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.chn_o_rsci_ivld = 1'b1;
      bus.chn_o_rsci_idat = DW'(17'h11 * (i + 1));
      cycle();
    end
    bus.chn_o_rsci_ivld = 1'b0;
    n_tests++;
    if (bus.chn_o_cnt !== CW'(2)) begin
      n_fail++;
      $display("FAIL rmid_fill: got cnt=%0d want 2", bus.chn_o_cnt);
    end
    #2 rstn = 1'b0;
    #1;
    mq.delete();
    m_ovf = 1'b0;
    n_tests++;
    if (dut_status() !== ST_IDLE) begin
      n_fail++;
      $display("FAIL rmid_async: got %b want %b", dut_status(), ST_IDLE);
    end
    @(negedge clk);
    rstn = 1'b1;
    bus.chn_o_rsci_ivld = 1'b1;
    bus.chn_o_rsci_idat = 17'h00055;
    cycle();
    bus.chn_o_rsci_ivld = 1'b0;
    bus.chn_o_prdy      = 1'b1;
    n_tests++;
    if (bus.chn_o_pvld !== 1'b1 || bus.chn_o_pd !== 17'h00055 || bus.chn_o_cnt !== CW'(1)) begin
      n_fail++;
      $display("FAIL rmid_first: got pvld=%b pd=%h cnt=%0d want pvld=1 pd=00055 cnt=1",
               bus.chn_o_pvld, bus.chn_o_pd, bus.chn_o_cnt);
    end
    cycle();
    n_tests++;
    if (dut_status() !== ST_IDLE) begin
      n_fail++;
      $display("FAIL rmid_drain: got %b want %b", dut_status(), ST_IDLE);
    end
    bus.chn_o_prdy = 1'b0;
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      bus.chn_o_rsci_ivld = ($urandom_range(0, 3) != 0);
      bus.chn_o_rsci_idat = DW'($urandom);
      bus.chn_o_prdy      = ($urandom_range(0, 2) != 0);
      cycle();
      n_tests++;
      if (dut_status() !== m_status() || (mq.size() != 0 && bus.chn_o_pd !== mq[0])) begin
        n_fail++;
        bad++;
        if (bad < 5)
          $display("FAIL random_%0d: got st=%b pd=%h want st=%b pd=%h",
                   i, dut_status(), bus.chn_o_pd, m_status(), (mq.size() != 0) ? mq[0] : '0);
      end
    end
    bus.chn_o_rsci_ivld = 1'b0;
    bus.chn_o_prdy      = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_stream();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
